// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory stage: memory opcodes, access sizes,
// the IDLE/BUSY state encoding and small lane helpers used when issuing a request.
package dm_pkg;

    // Memory opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Request FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dm_state_e;

    // Access width of a memory operation
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Any opcode that is not a byte or halfword access is treated as a word access,
    // so a stray opcode carrying MemRead/MemWrite still behaves predictably.
    function automatic mem_size_e op_size(input logic [5:0] op);
        mem_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Only LB and LH sign-extend their result.
    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] lane_be(input mem_size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane so the byte enables alone pick the target.
    function automatic logic [31:0] lane_data(input mem_size_e sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/halfword out of a
// little-endian read word and sign- or zero-extends it to 32 bits.
module load_align
    import dm_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Split the read word into its four byte lanes (lane 0 = least significant).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    // Select the addressed lane(s) and extend to the full register width.
    always_comb begin
        byte_sel = lane[offset];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// Data-memory pipeline stage: decodes the memory operation, issues a single
// registered request per access, freezes upstream until the access completes,
// and loads the DM/WB pipeline register.
module dm_stage
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instructionDM,
    input  logic [31:0] ALUresDM,
    input  logic [31:0] DMRead2,
    input  logic        DMMemRead,
    input  logic        DMMemWrite,
    input  logic        DMMemToReg,
    input  logic        DMRegWrite,
    input  logic [4:0]  DMwriteReg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] WBinstruction,
    output logic [31:0] WBALUres,
    output logic [31:0] WBreadData,
    output logic        WBMemToReg,
    output logic        WBRegWrite,
    output logic [4:0]  WBwriteReg,
    output logic        WBmisalign
);

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    logic [5:0] opcode;
    mem_size_e  op_sz;
    logic       memop;
    logic       misaligned;
    logic       aligned_memop;

    assign opcode        = instructionDM[31:26];
    assign op_sz         = op_size(opcode);
    assign memop         = DMMemRead | DMMemWrite;
    assign aligned_memop = memop & ~misaligned;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
    always_comb begin
        misaligned = 1'b0;
        if (memop) begin
            case (op_sz)
                SZ_HALF: misaligned = ALUresDM[0];
                SZ_WORD: misaligned = (ALUresDM[1:0] != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Request FSM
    // ---------------------------------------------------------------
    dm_state_e state_q, state_d;
    logic      issue;
    logic      complete;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stall: the issuing cycle always stalls, so every access costs at least one cycle.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        issue    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_memop) begin
                    state_d = ST_BUSY;
                    stall   = 1'b1;
                    issue   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d  = ST_IDLE;
                    complete = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Request registers (held stable for the whole BUSY period)
    // ---------------------------------------------------------------
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        ld_q;       // access returns data to the register file
    logic [1:0]  ld_off_q;   // byte offset inside the word
    mem_size_e   ld_size_q;
    logic        ld_sign_q;

    // Capture the request on issue; drop mem_req when the acknowledge arrives.
    // A store wins over a load when both controls are set, so no load data is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            ld_q        <= 1'b0;
            ld_off_q    <= '0;
            ld_size_q   <= SZ_WORD;
            ld_sign_q   <= 1'b0;
        end else if (issue) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= DMMemWrite;
            mem_addr_q  <= {ALUresDM[31:2], 2'b00};
            mem_be_q    <= lane_be(op_sz, ALUresDM[1:0]);
            mem_wdata_q <= lane_data(op_sz, DMRead2);
            ld_q        <= DMMemRead & ~DMMemWrite;
            ld_off_q    <= ALUresDM[1:0];
            ld_size_q   <= op_sz;
            ld_sign_q   <= op_signed(opcode);
        end else if (complete) begin
            mem_req_q   <= 1'b0;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

    // ---------------------------------------------------------------
    // Load data alignment
    // ---------------------------------------------------------------
    logic [31:0] load_data;

    load_align u_load_align (
        .rdata    (mem_rdata),
        .offset   (ld_off_q),
        .size     (ld_size_q),
        .sign_ext (ld_sign_q),
        .data     (load_data)
    );

    // ---------------------------------------------------------------
    // DM/WB pipeline register
    // ---------------------------------------------------------------
    logic [31:0] wb_instr_q;
    logic [31:0] wb_alu_q;
    logic [31:0] wb_rdata_q;
    logic        wb_m2r_q;
    logic        wb_rw_q;
    logic [4:0]  wb_wreg_q;
    logic        wb_mis_q;

    // Advance when not stalled, otherwise insert a bubble; read data only changes on a completed load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_instr_q <= '0;
            wb_alu_q   <= '0;
            wb_rdata_q <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_wreg_q  <= '0;
            wb_mis_q   <= 1'b0;
        end else if (!stall) begin
            wb_instr_q <= instructionDM;
            wb_alu_q   <= ALUresDM;
            wb_m2r_q   <= DMMemToReg;
            wb_rw_q    <= DMRegWrite & ~misaligned;
            wb_wreg_q  <= DMwriteReg;
            wb_mis_q   <= misaligned;
            if (complete && ld_q) begin
                wb_rdata_q <= load_data;
            end
        end else begin
            wb_instr_q <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_mis_q   <= 1'b0;
        end
    end

    assign WBinstruction = wb_instr_q;
    assign WBALUres      = wb_alu_q;
    assign WBreadData    = wb_rdata_q;
    assign WBMemToReg    = wb_m2r_q;
    assign WBRegWrite    = wb_rw_q;
    assign WBwriteReg    = wb_wreg_q;
    assign WBmisalign    = wb_mis_q;

endmodule
